mod_mul_il_arbiter: RTL and testbench

- Shares one interleaved modular multiplier instance among NREQ requesters.
- Grants requesters round-robin and latches the granted requester's operands.
- Pre-checks operand legality, then fires the multiplier start pulse and waits for its done pulse, with a timeout.
- Returns the result, requester id and error flag on a single valid/ready response channel.
- Sits between the crypto-core command fabric and the mod_mul_il datapath.

---
 rtl/mod_mul_il_arbiter.sv | 155 +++++++++++++++
 tb/tb_mod_mul_il_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_mul_il_arbiter.sv
// rtl/mod_mul_il_arbiter.sv - round-robin arbiter sharing one interleaved modular multiplier among NREQ requesters
// Grants one request at a time, screens operands, runs the multiplier with a timeout, returns one response.
module mod_mul_il_arbiter #(
    parameter int NBITS   = 4,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 256,
    parameter int TW      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    input  logic [NREQ*NBITS-1:0] req_m,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [NBITS-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic                  mm_enable_p,
    output logic [NBITS-1:0]      mm_a,
    output logic [NBITS-1:0]      mm_b,
    output logic [NBITS-1:0]      mm_m,
    input  logic [NBITS-1:0]      mm_y,
    input  logic                  mm_done_irq_p,
    output logic                  busy
);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t            r_state, w_next;
    logic [IDW-1:0]    r_rr_ptr, r_op_id, w_gnt, w_gnt_inc;
    logic [NBITS-1:0]  r_op_a, r_op_b, r_op_m, r_rsp_y;
    logic [NBITS-1:0]  w_sel_a, w_sel_b, w_sel_m;
    logic [TW-1:0]     r_cnt;
    logic              r_rsp_err;
    logic              w_gnt_found, w_illegal, w_timeout;
    logic [2*NREQ-1:0] w_req_dbl;
    logic [NREQ-1:0]   w_req_rot;
    logic [IDW:0]      w_sum;

    // Rotate the request vector so that bit 0 is the requester at rr_ptr.
    assign w_req_dbl = {req_valid, req_valid} >> r_rr_ptr;
    assign w_req_rot = w_req_dbl[NREQ-1:0];

    always_comb begin
        w_gnt_found = 1'b0;
        w_sum       = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (w_req_rot[i]) begin
                w_gnt_found = 1'b1;
                w_sum       = {1'b0, r_rr_ptr} + (IDW+1)'(i);
            end
        end
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
        w_gnt = w_sum[IDW-1:0];
    end

    assign w_gnt_inc = (w_gnt == IDW'(NREQ - 1)) ? '0 : w_gnt + 1'b1;

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        w_sel_m = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_gnt == IDW'(k)) begin
                w_sel_a = req_a[k*NBITS +: NBITS];
                w_sel_b = req_b[k*NBITS +: NBITS];
                w_sel_m = req_m[k*NBITS +: NBITS];
            end
        end
    end

    assign w_illegal = (r_op_m == '0) || (r_op_a >= r_op_m) || (r_op_b >= r_op_m);
    assign w_timeout = (r_cnt == TW'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        case (r_state)
            S_IDLE: begin
                if (w_gnt_found && rst_n) begin
                    req_ready = NREQ'(1) << w_gnt;
                    w_next    = S_CHECK;
                end
            end
            S_CHECK: w_next = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (mm_done_irq_p || w_timeout) w_next = S_RESP;
            S_RESP:  if (rsp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_op_id   <= '0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_m    <= '0;
            r_cnt     <= '0;
            r_rsp_y   <= '0;
            r_rsp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_found) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_op_m   <= w_sel_m;
                        r_op_id  <= w_gnt;
                        r_rr_ptr <= w_gnt_inc;
                    end
                end
                S_CHECK: begin
                    if (w_illegal) begin
                        r_rsp_y   <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    // A done pulse in the timeout cycle still delivers the real result.
                    if (mm_done_irq_p) begin
                        r_rsp_y   <= mm_y;
                        r_rsp_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_rsp_y   <= '0;
                        r_rsp_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid   = (r_state == S_RESP);
    assign rsp_id      = r_op_id;
    assign rsp_y       = r_rsp_y;
    assign rsp_err     = r_rsp_err;
    assign mm_enable_p = (r_state == S_ISSUE);
    assign mm_a        = r_op_a;
    assign mm_b        = r_op_b;
    assign mm_m        = r_op_m;
    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_mod_mul_il_arbiter.sv
// tb/tb_mod_mul_il_arbiter.sv - self-checking bench for mod_mul_il_arbiter
// Directed steps then random traffic, checked against an arithmetic round-robin/modmul model.
module tb_mod_mul_il_arbiter;

    localparam int NBITS = 4, NREQ = 4, IDW = 2, TIMEOUT = 16, TW = 16;

    typedef struct packed { logic [NBITS-1:0] a, b, m; } op_t;
    typedef struct packed { logic [IDW-1:0] id; logic [NBITS-1:0] y; logic err; } rsp_t;

    logic                  clk = 1'b0, rst_n = 1'b0;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*NBITS-1:0] req_a = '0, req_b = '0, req_m = '0;
    logic                  rsp_valid, rsp_ready = 1'b1, rsp_err;
    logic [IDW-1:0]        rsp_id;
    logic [NBITS-1:0]      rsp_y, mm_a, mm_b, mm_m, mm_y = '0;
    logic                  mm_enable_p, mm_done_irq_p = 1'b0, busy;

    mod_mul_il_arbiter #(.NBITS(NBITS), .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_m(req_m), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_err(rsp_err), .mm_enable_p(mm_enable_p),
        .mm_a(mm_a), .mm_b(mm_b), .mm_m(mm_m), .mm_y(mm_y), .mm_done_irq_p(mm_done_irq_p), .busy(busy)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0, n_err = 0, n_rsp = 0, starts = 0, viol = 0, cyc = 0;
    int   acc_cyc = 0, en_cyc = 0, rv_cyc = 0, ptr = 0, g, pred, cd = 0, mm_lat = 3;
    bit   mm_never = 1'b0, mm_stale = 1'b0, prev_v = 1'b0;
    logic [NBITS-1:0] pend_y = '0;
    op_t  pend[NREQ][$];
    op_t  mon_op;
    rsp_t exp_q[$];
    rsp_t last_rsp = '0;
    int   grant_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t mk(input int id, input int y, input bit e);
        rsp_t r;
        r.id = IDW'(id); r.y = NBITS'(y); r.err = e;
        return r;
    endfunction

    // Expected response straight from the operand rules: legal -> a*b mod m, else error with 0.
    function automatic rsp_t model(input int k, input op_t op, input bit never);
        if (op.m == 0 || op.a >= op.m || op.b >= op.m || never) return mk(k, 0, 1'b1);
        return mk(k, (int'(op.a) * int'(op.b)) % int'(op.m), 1'b0);
    endfunction

    function automatic logic [31:0] gpack(input int base, input int n);
        logic [31:0] r = '0;
        for (int i = 0; i < n; i++)
            r = (r << 4) | ((base + i < grant_q.size()) ? 32'(grant_q[base + i]) : 32'hF);
        return r;
    endfunction

    function automatic logic [31:0] outs();
        return 32'({req_ready, rsp_valid, rsp_id, rsp_y, rsp_err, mm_enable_p, mm_a, mm_b, mm_m, busy});
    endfunction

    always @(posedge clk) cyc = cyc + 1;

    // Requesters: each presents the head of its pending queue and holds it until granted.
    initial forever begin
        @(posedge clk); #1;
        for (int k = 0; k < NREQ; k++) begin
            if (pend[k].size() > 0) begin
                req_valid[k] = 1'b1;
                req_a[k*NBITS +: NBITS] = pend[k][0].a;
                req_b[k*NBITS +: NBITS] = pend[k][0].b;
                req_m[k*NBITS +: NBITS] = pend[k][0].m;
            end else begin
                req_valid[k] = 1'b0;
            end
        end
    end

    // Multiplier stand-in: result mm_lat cycles after the start pulse, optional stale pulse at start.
    initial forever begin
        @(posedge clk); #1;
        mm_done_irq_p = 1'b0;
        if (!rst_n) cd = 0;
        else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin mm_done_irq_p = 1'b1; mm_y = pend_y; end
            end
            if (mm_enable_p) begin
                if (mm_stale) begin mm_done_irq_p = 1'b1; mm_y = '1; end
                if (!mm_never && mm_m != 0) begin
                    cd = mm_lat;
                    pend_y = NBITS'((int'(mm_a) * int'(mm_b)) % int'(mm_m));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) prev_v = 1'b0;
        else begin
            if ($countones(req_ready) > 1 || (req_ready != 0 && busy)) viol++;
            if (req_ready != 0) begin
                g = 0; pred = -1;
                for (int k = 0; k < NREQ; k++) if (req_ready[k]) g = k;
                for (int i = 0; i < NREQ; i++)
                    if (pred < 0 && req_valid[(ptr + i) % NREQ]) pred = (ptr + i) % NREQ;
                chk("grant", 32'(g), 32'(pred));
                ptr = (g + 1) % NREQ;
                if (pend[g].size() == 0) chk("grant_without_request", 32'(g), 32'hFFFF);
                else begin
                    mon_op = pend[g].pop_front();
                    exp_q.push_back(model(g, mon_op, mm_never));
                end
                grant_q.push_back(g);
                acc_cyc = cyc;
            end
            if (mm_enable_p) begin starts++; en_cyc = cyc; end
            if (rsp_valid && !prev_v) rv_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                last_rsp = {rsp_id, rsp_y, rsp_err};
                if (exp_q.size() == 0) chk("rsp_unexpected", 32'(last_rsp), 32'hFFFF);
                else chk("rsp", 32'(last_rsp), 32'(exp_q.pop_front()));
                n_rsp++;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input int k, input int a, input int b, input int m);
        op_t o;
        o.a = NBITS'(a); o.b = NBITS'(b); o.m = NBITS'(m);
        pend[k].push_back(o);
    endtask

    task automatic wait_rsps(input int n, input int budget);
        int c = 0;
        while (n_rsp < n && c < budget) begin step(); c++; end
        if (n_rsp < n) chk("wait_rsp_budget", 32'(n_rsp), 32'(n));
    endtask

    task automatic reset_begin();
        rst_n = 1'b0;
        for (int k = 0; k < NREQ; k++) pend[k].delete();
        exp_q.delete(); grant_q.delete(); ptr = 0;
    endtask

    initial begin
        int tgt, s0, gb, rb, pushed, c, m;
        logic [31:0] snap;

        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 0);
        for (int k = 0; k < NREQ; k++) push(k, k, k + 1, 11);
        step(); @(negedge clk);
        chk("reset_no_ready", 32'(req_ready), 0);
        step(); rst_n = 1'b1;
        wait_rsps(4, 200);
        chk("grant_order_all", gpack(0, 4), 32'h0123);

        push(0, 1, 2, 3); push(0, 2, 2, 5); push(2, 3, 3, 4); push(2, 7, 7, 13);
        wait_rsps(8, 300);
        chk("grant_order_0_2", gpack(4, 4), 32'h0202);

        mm_stale = 1'b1; mm_lat = 3; s0 = starts; tgt = n_rsp + 1;
        push(1, 5, 6, 7);
        wait_rsps(tgt, 100);
        mm_stale = 1'b0;
        chk("basic_rsp", 32'(last_rsp), 32'(mk(1, 2, 1'b0)));
        chk("enable_latency", 32'(en_cyc - acc_cyc), 2);
        chk("rsp_latency", 32'(rv_cyc - acc_cyc), 32'(3 + mm_lat));
        chk("one_start", 32'(starts - s0), 1);

        s0 = starts; tgt = n_rsp + 1;
        push(3, 1, 1, 0);
        wait_rsps(tgt, 100);
        chk("illegal_m0", 32'(last_rsp), 32'(mk(3, 0, 1'b1)));
        push(3, 9, 1, 7);
        wait_rsps(tgt + 1, 100);
        chk("illegal_a_ge_m", 32'(last_rsp), 32'(mk(3, 0, 1'b1)));
        chk("illegal_no_start", 32'(starts), 32'(s0));

        mm_never = 1'b1; tgt = n_rsp + 1;
        push(1, 3, 4, 5);
        wait_rsps(tgt, 100);
        chk("timeout_rsp", 32'(last_rsp), 32'(mk(1, 0, 1'b1)));
        chk("timeout_cycles", 32'(rv_cyc - en_cyc), 32'(TIMEOUT + 1));
        mm_never = 1'b0; mm_lat = TIMEOUT;
        push(1, 3, 4, 5);
        wait_rsps(tgt + 1, 100);
        chk("done_beats_timeout", 32'(last_rsp), 32'(mk(1, 2, 1'b0)));
        chk("done_tie_cycles", 32'(rv_cyc - en_cyc), 32'(TIMEOUT + 1));

        mm_lat = 3; rsp_ready = 1'b0; gb = grant_q.size(); tgt = n_rsp + 3;
        push(0, 2, 3, 5); push(1, 4, 4, 7); push(2, 6, 5, 11);
        c = 0;
        do begin @(negedge clk); c++; end while (!rsp_valid && c < 60);
        snap = 32'({rsp_id, rsp_y, rsp_err});
        chk("stall_first_rsp", snap, 32'(mk(2, 8, 1'b0)));
        repeat (5) begin
            @(negedge clk);
            chk("stall_hold", 32'({rsp_valid, rsp_id, rsp_y, rsp_err}), snap | 32'h80);
            chk("stall_no_ready", 32'(req_ready), 0);
        end
        step(); rsp_ready = 1'b1;
        wait_rsps(tgt, 200);
        chk("grant_after_stall", gpack(gb, 3), 32'h201);

        mm_never = 1'b1; s0 = starts;
        push(2, 1, 2, 3);
        c = 0;
        while (starts == s0 && c < 20) begin step(); c++; end
        step(); step();
        rb = n_rsp;
        reset_begin();
        @(negedge clk);
        chk("reset_mid_wait", outs(), 0);
        mm_never = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("no_rsp_after_reset", 32'(n_rsp), 32'(rb));
        push(3, 1, 1, 2); push(0, 1, 1, 2);
        wait_rsps(rb + 2, 100);
        chk("grant_after_reset", gpack(0, 2), 32'h03);

        rb = n_rsp; pushed = 0; c = 0;
        while ((pushed < 40 || n_rsp < rb + 40) && c < 6000) begin
            step(); c++;
            rsp_ready = ($urandom_range(0, 3) != 0);
            mm_lat = int'($urandom_range(1, TIMEOUT));
            if (pushed < 40 && $urandom_range(0, 2) == 0) begin
                m = int'($urandom_range(0, 15));
                if (m > 0 && $urandom_range(0, 4) != 0)
                    push(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, m - 1)),
                         int'($urandom_range(0, m - 1)), m);
                else
                    push(int'($urandom_range(0, NREQ - 1)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)), m);
                pushed++;
            end
        end
        rsp_ready = 1'b1;
        chk("random_rsp_count", 32'(n_rsp), 32'(rb + 40));
        chk("random_exp_drained", 32'(exp_q.size()), 0);
        chk("ready_onehot_idle_only", 32'(viol), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
